// File: rtl/rx_session_pkg.sv
// Shared types and constants for the RX session controller.
// Session states and the completion status codes reported to the host.
package rx_session_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TERM = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_ABORT   = 2'b10;

endpackage

// File: rtl/rx_watchdog.sv
// Starvation watchdog: counts consecutive idle cycles and flags the last one
// before the timeout limit is reached.
module rx_watchdog #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_reg;

    // Saturates at LAST so the counter can never wrap back to a fresh window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && !expire) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign expire = (cnt_reg == LAST);

endmodule

// File: rtl/rx_session_ctrl.sv
// RX session controller: gates the Darwin3 RX stream towards the DMA for one
// host-commanded burst, marks the final beat and reports completion status.
module rx_session_ctrl
    import rx_session_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int LEN_W       = 32,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic                cmd_abort,
    output logic                rx_en,
    input  logic [DATA_W-1:0]   s_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [DATA_W/8-1:0] m_axis_tkeep,
    output logic                m_axis_tlast,
    output logic                sess_busy,
    output logic                sess_done,
    output logic [1:0]          sess_status,
    output logic [LEN_W-1:0]    sess_beats
);

    state_t           state_reg, state_next;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] beat_cnt_reg;
    logic [1:0]       term_status_reg, term_status_next;
    logic             rx_en_reg;
    logic [1:0]       sess_status_reg;
    logic [LEN_W-1:0] sess_beats_reg;
    logic [1:0]       done_status;
    logic [LEN_W-1:0] done_beats;

    logic in_run;
    logic beat;
    logic is_last;
    logic wd_expire;
    logic timeout;

    assign in_run  = (state_reg == RUN);
    assign beat    = in_run && s_axis_tvalid && m_axis_tready;
    assign is_last = (beat_cnt_reg == len_reg - LEN_W'(1));
    assign timeout = in_run && !s_axis_tvalid && wd_expire;

    rx_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!in_run || s_axis_tvalid),
        .inc   (in_run && !s_axis_tvalid),
        .expire(wd_expire)
    );

    // Final beat wins over abort, abort wins over timeout.
    always_comb begin
        state_next       = state_reg;
        term_status_next = term_status_reg;
        done_status      = ST_OK;
        done_beats       = beat_cnt_reg;
        case (state_reg)
            IDLE: begin
                done_beats = '0;
                if (cmd_valid) begin
                    state_next = (cmd_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (beat && is_last) begin
                    state_next = DONE;
                    done_beats = beat_cnt_reg + LEN_W'(1);
                end else if (cmd_abort) begin
                    state_next       = TERM;
                    term_status_next = ST_ABORT;
                end else if (timeout) begin
                    state_next       = TERM;
                    term_status_next = ST_TIMEOUT;
                end
            end
            TERM: begin
                done_status = term_status_reg;
                if (m_axis_tready) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            len_reg         <= '0;
            beat_cnt_reg    <= '0;
            term_status_reg <= ST_OK;
            rx_en_reg       <= 1'b0;
            sess_status_reg <= ST_OK;
            sess_beats_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            term_status_reg <= term_status_next;
            rx_en_reg       <= (state_next == RUN);
            if (state_reg == IDLE && cmd_valid) begin
                len_reg      <= cmd_len;
                beat_cnt_reg <= '0;
            end else if (beat) begin
                beat_cnt_reg <= beat_cnt_reg + LEN_W'(1);
            end
            if (state_next == DONE && state_reg != DONE) begin
                sess_status_reg <= done_status;
                sess_beats_reg  <= done_beats;
            end
        end
    end

    // Stream muxing: transparent in RUN, a zero-keep terminator in TERM.
    always_comb begin
        s_axis_tready = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        if (state_reg == RUN) begin
            s_axis_tready = m_axis_tready;
            m_axis_tdata  = s_axis_tdata;
            m_axis_tvalid = s_axis_tvalid;
            m_axis_tkeep  = '1;
            m_axis_tlast  = is_last;
        end else if (state_reg == TERM) begin
            m_axis_tvalid = 1'b1;
            m_axis_tlast  = 1'b1;
        end
    end

    assign cmd_ready   = (state_reg == IDLE);
    assign sess_busy   = (state_reg != IDLE);
    assign sess_done   = (state_reg == DONE);
    assign rx_en       = rx_en_reg;
    assign sess_status = sess_status_reg;
    assign sess_beats  = sess_beats_reg;

endmodule

// File: tb/tb_rx_session_ctrl.sv
// Scoreboard bench for rx_session_ctrl: directed and random sessions, expected
// beats and session results queued by the driver and checked by a monitor.
module tb_rx_session_ctrl;
    import rx_session_pkg::*;

    localparam int DATA_W = 16;
    localparam int LEN_W  = 32;
    localparam int TO     = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic              cmd_abort = 1'b0;
    logic              rx_en;
    logic [DATA_W-1:0] s_axis_tdata = '0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b1;
    logic [1:0]        m_axis_tkeep;
    logic              m_axis_tlast;
    logic              sess_busy;
    logic              sess_done;
    logic [1:0]        sess_status;
    logic [LEN_W-1:0]  sess_beats;

    rx_session_ctrl #(.DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_abort(cmd_abort),
        .rx_en(rx_en),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .sess_busy(sess_busy), .sess_done(sess_done), .sess_status(sess_status), .sess_beats(sess_beats)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] data; logic [1:0] keep; logic last; } beat_t;
    typedef struct { logic [1:0] status; logic [31:0] beats; } res_t;

    beat_t       exp_beats[$];
    res_t        exp_res[$];
    logic [15:0] src[$];
    int          compared = 0;
    int          mismatched = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: sampled on the falling edge, away from the active edge.
    logic prev_done = 1'b0;
    logic prev_term = 1'b0;
    int   starve_run = 0;
    always @(negedge clk) begin
        beat_t b;
        res_t  r;
        if (rst_n) begin
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_beats.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL unexpected_beat: got data %0h keep %0h last %0b, none expected",
                             m_axis_tdata, m_axis_tkeep, m_axis_tlast);
                end else begin
                    b = exp_beats.pop_front();
                    check("beat_data", m_axis_tdata, b.data);
                    check("beat_keep", m_axis_tkeep, b.keep);
                    check("beat_last", m_axis_tlast, b.last);
                    $display("beat data=%h keep=%b last=%b", m_axis_tdata, m_axis_tkeep, m_axis_tlast);
                end
            end
            if (m_axis_tvalid && m_axis_tkeep == 2'b00 && !prev_term &&
                exp_res.size() > 0 && exp_res[0].status == ST_TIMEOUT)
                check("timeout_cycles", starve_run, TO);
            prev_term = m_axis_tvalid && (m_axis_tkeep == 2'b00);
            if (sess_done) begin
                check("done_width", prev_done, 1'b0);
                if (exp_res.size() == 0) begin
                    compared++; mismatched++;
                    $display("FAIL unexpected_done: got status %0h beats %0d, no session pending",
                             sess_status, sess_beats);
                end else begin
                    r = exp_res.pop_front();
                    check("sess_status", sess_status, r.status);
                    check("sess_beats", sess_beats, r.beats);
                    $display("done status=%b beats=%0d", sess_status, sess_beats);
                end
            end
            prev_done  = sess_done;
            starve_run = (rx_en && !s_axis_tvalid) ? starve_run + 1 : 0;
        end else begin
            prev_done  = 1'b0;
            prev_term  = 1'b0;
            starve_run = 0;
        end
    end

    task automatic fill_src(input int n, input bit ramp);
        src.delete();
        for (int i = 0; i < n; i++)
            src.push_back(ramp ? 16'((i + 1) * 16'h1111) : 16'($urandom));
    endtask

    // One host session. abort_at: abort on that beat (0 = none); nsend < len
    // starves the stream; reset_after > 0 pulls rst_n once that many beats passed.
    task automatic run_session(input int len, input int nsend, input int abort_at, input int stall,
                               input bit ready_always, input bit tog, input int reset_after);
        int exp_n, sent, stalled, cyc, gap, g;
        logic [1:0] st;
        bit v, r, a;
        if (len == 0) begin
            exp_n = 0; st = ST_OK;
        end else if (abort_at > 0) begin
            exp_n = abort_at; st = (abort_at == len) ? ST_OK : ST_ABORT;
        end else if (nsend < len) begin
            exp_n = nsend; st = ST_TIMEOUT;
        end else begin
            exp_n = len; st = ST_OK;
        end
        for (int i = 0; i < exp_n; i++) exp_beats.push_back('{src[i], 2'b11, (i == len - 1)});
        if (st != ST_OK) exp_beats.push_back('{16'h0, 2'b00, 1'b1});
        exp_res.push_back('{st, 32'(exp_n)});
        $display("session len=%0d send=%0d abort_at=%0d expect status=%b beats=%0d",
                 len, nsend, abort_at, st, exp_n);

        @(posedge clk); #1;
        g = 0;
        while (!cmd_ready && g < 100) begin @(posedge clk); #1; g++; end
        if (g >= 100) begin compared++; mismatched++; $display("FAIL cmd_ready_wait: got 0 required 1"); end
        cmd_valid = 1'b1; cmd_len = 32'(len);
        @(posedge clk); #1;
        cmd_valid = 1'b0;

        sent = 0; stalled = 0; cyc = 0; gap = 0;
        while (cyc < 3000) begin
            if (reset_after > 0 && sent == reset_after) begin
                s_axis_tvalid = 1'b1; s_axis_tdata = src[sent]; m_axis_tready = 1'b1;
                rst_n = 1'b0;
                #1;
                check("rst_rx_en", rx_en, 1'b0);
                check("rst_busy", sess_busy, 1'b0);
                check("rst_m_tvalid", m_axis_tvalid, 1'b0);
                check("rst_status", sess_status, 2'b00);
                check("rst_beats", sess_beats, 0);
                exp_beats.delete(); exp_res.delete();
                s_axis_tvalid = 1'b0;
                #2 rst_n = 1'b1;
                break;
            end
            v = 1'b0; a = 1'b0;
            if (sent < nsend) v = (gap >= 2) || ($urandom_range(0, 3) != 0);
            r = ready_always ? 1'b1 : (tog ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0));
            if (stall > 0 && sent == 1 && sent < nsend && stalled < stall) begin
                v = 1'b1; r = 1'b0; stalled++;
            end
            if (abort_at > 0 && sent == abort_at - 1) begin v = 1'b1; r = 1'b1; a = 1'b1; end
            s_axis_tvalid = v;
            s_axis_tdata  = v ? src[sent] : 16'($urandom);
            m_axis_tready = r;
            cmd_abort     = a;
            gap = v ? 0 : gap + 1;
            @(negedge clk);
            if (cyc == 0) begin
                if (len == 0) begin
                    check("len0_done", sess_done, 1'b1);
                    check("len0_rx_en", rx_en, 1'b0);
                    check("len0_m_tvalid", m_axis_tvalid, 1'b0);
                end else begin
                    check("rx_en_start", rx_en, 1'b1);
                end
            end
            if (s_axis_tvalid && s_axis_tready) sent++;
            if (!sess_busy) break;
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 3000) begin compared++; mismatched++; $display("FAIL session_timeout: session never ended"); end
        s_axis_tvalid = 1'b0; cmd_abort = 1'b0; m_axis_tready = 1'b1;
    endtask

    initial begin
        int kind, len;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 1'b1);
        check("reset_rx_en", rx_en, 1'b0);
        check("reset_busy", sess_busy, 1'b0);
        check("reset_done", sess_done, 1'b0);
        check("reset_status", sess_status, 2'b00);
        check("reset_beats", sess_beats, 0);
        check("reset_m_tvalid", m_axis_tvalid, 1'b0);
        check("reset_m_tlast", m_axis_tlast, 1'b0);
        check("reset_m_tkeep", m_axis_tkeep, 2'b00);
        check("reset_s_tready", s_axis_tready, 1'b0);

        fill_src(4, 1'b1);  run_session(4, 4, 0, 0, 1'b1, 1'b0, 0);
        fill_src(3, 1'b0);  run_session(3, 3, 0, 0, 1'b0, 1'b1, 0);
        fill_src(3, 1'b0);  run_session(3, 3, 0, 40, 1'b0, 1'b0, 0);
        fill_src(8, 1'b0);  run_session(8, 2, 0, 0, 1'b1, 1'b0, 0);
        fill_src(8, 1'b0);  run_session(8, 0, 0, 0, 1'b0, 1'b0, 0);
        fill_src(8, 1'b0);  run_session(8, 8, 3, 0, 1'b0, 1'b0, 0);
        fill_src(3, 1'b0);  run_session(3, 3, 3, 0, 1'b0, 1'b0, 0);
        fill_src(0, 1'b0);  run_session(0, 0, 0, 0, 1'b1, 1'b0, 0);
        fill_src(10, 1'b0); run_session(10, 10, 0, 0, 1'b1, 1'b0, 5);
        fill_src(2, 1'b0);  run_session(2, 2, 0, 0, 1'b1, 1'b0, 0);

        for (int s = 0; s < 40; s++) begin
            kind = $urandom_range(0, 3);
            if (kind <= 1) begin
                len = $urandom_range(1, 12); fill_src(len, 1'b0);
                run_session(len, len, 0, 0, 1'b0, 1'b0, 0);
            end else if (kind == 2) begin
                len = $urandom_range(2, 10); fill_src(len, 1'b0);
                run_session(len, $urandom_range(0, len - 1), 0, 0, 1'b0, 1'b0, 0);
            end else begin
                len = $urandom_range(1, 10); fill_src(len, 1'b0);
                run_session(len, len, $urandom_range(1, len), 0, 1'b0, 1'b0, 0);
            end
        end

        repeat (5) @(negedge clk);
        check("beats_left", exp_beats.size(), 0);
        check("results_left", exp_res.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
